seven_segments_value_decoder: RTL and testbench
===============================================

Name: seven_segments_value_decoder

Overview:
Converts an 8-bit binary value into two active-high seven-segment patterns, one per display digit. It sits directly upstream of the two-digit multiplexed display driver and feeds that driver's digit_0 and digit_1 segment inputs. Decimal mode uses a sequential double-dabble (shift-add-3) converter. Hex mode decodes the two nibbles directly. Both output patterns are held stable between updates.

Parameters:
BLANK_LEADING_ZERO, 1, when 1 the tens/high digit is blanked (7'h00) if it is zero; when 0 it shows "0".

Ports:
i_clock  input  1  system clock, all state updates on rising edge
i_reset_n  input  1  asynchronous active-low reset; deassertion is synchronised externally
i_value  input  8  binary value to display
i_hex_mode  input  1  1 = two hex digits, 0 = two decimal digits
i_valid  input  1  request to convert i_value; accepted only when o_busy = 0
o_busy  output  1  conversion in progress; new requests are ignored
o_done  output  1  one-cycle pulse on the edge the outputs update
o_segments_digit_0  output  7  ones/low-nibble digit pattern, active high
o_segments_digit_1  output  7  tens/high-nibble digit pattern, active high

Behaviour:
- Segment bit order: [6:0] = {g,f,e,d,c,b,a}.
- Digit patterns:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
  - A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71.
  - Dash = 40. Blank = 00.
- Reset (i_reset_n = 0, asynchronous):
  - State goes to IDLE.
  - o_busy = 0, o_done = 0.
  - Both segment outputs = 7'h00.
  - The iteration counter and shift register are cleared.
- States: IDLE, CONVERT, DECODE.
- IDLE:
  - On edge E0 with i_valid = 1, latch i_value and i_hex_mode, and set o_busy = 1.
  - If hex mode, go to DECODE. If decimal mode, go to CONVERT with the 20-bit shift register = {12'b0, i_value} and the 3-bit counter = 0.
- CONVERT, one iteration per cycle:
  - Each BCD nibble (hundreds, tens, ones) that is >= 5 gets +3.
  - Then the whole 20-bit register shifts left by 1.
  - The counter increments. After the 8th iteration (counter = 7, edge E8) go to DECODE.
- DECODE, one cycle:
  - Segment outputs are registered, o_done = 1 for exactly this edge's following cycle, o_busy = 0, state goes to IDLE.
  - Decimal latency: outputs valid after E9. Hex latency: outputs valid after E1.
- Decimal decode:
  - If hundreds != 0 (value > 99), both digits show dash (40, 40).
  - Otherwise digit_1 = tens and digit_0 = ones.
- Hex decode: digit_1 = i_value[7:4], digit_0 = i_value[3:0].
- Leading-zero blanking: with BLANK_LEADING_ZERO = 1 and the digit_1 source = 0, digit_1 = 00. This applies in both modes. digit_0 is never blanked.
- Between updates: o_busy is high from the cycle after E0 until DECODE completes. i_valid while busy is dropped, not queued. Segment outputs hold their previous values until DECODE writes them.
- i_value and i_hex_mode changing after acceptance have no effect on the running conversion.
- i_valid sampled high in the same cycle that DECODE completes is ignored, because o_busy is still 1 on that edge. The next acceptance happens at the earliest on the following edge.
- Reset mid-CONVERT: the conversion aborts immediately, outputs blank, and o_done does not pulse.
- Back-to-back decimal throughput: one conversion per 10 cycles.

Test Plan:
- Reset, then decimal i_value = 42 with i_valid for 1 cycle -> o_busy high for 9 cycles; after E9 digit_1 = 66, digit_0 = 5B, o_done high exactly 1 cycle.
- Decimal 7 with BLANK_LEADING_ZERO = 1 -> digit_1 = 00, digit_0 = 07. Repeat with parameter 0 -> digit_1 = 3F. Decimal 0 -> 00/3F. Decimal 99 -> 6F/6F.
- Decimal 100 and 255 -> both digits 40. Decimal 10 -> 06/3F.
- Hex mode i_value = 8'hA5 -> after E1 digit_1 = 77, digit_0 = 6D, o_done pulses. Hex 8'h0F -> 00/71 with blanking enabled.
- Accept decimal 42, then pulse i_valid with 13 at E3 and change i_value -> result still 66/5B, 13 never displayed. o_done pulses once.
- Accept decimal 42, assert i_reset_n = 0 at E4 -> outputs 00/00 and o_busy 0 immediately. No o_done pulse. After release, a new request for 5 completes normally -> 00/6D.

Source files
------------

// File: rtl/seven_segments_value_decoder_if.sv
// rtl/seven_segments_value_decoder_if.sv - request/result bundle for the seven-segment value decoder
interface seven_segments_value_decoder_if;
  logic [7:0] i_value;
  logic       i_hex_mode;
  logic       i_valid;
  logic       o_busy;
  logic       o_done;
  logic [6:0] o_segments_digit_0;
  logic [6:0] o_segments_digit_1;

  modport master (
    output i_value, i_hex_mode, i_valid,
    input  o_busy, o_done, o_segments_digit_0, o_segments_digit_1
  );

  modport slave (
    input  i_value, i_hex_mode, i_valid,
    output o_busy, o_done, o_segments_digit_0, o_segments_digit_1
  );
endinterface

// File: rtl/seven_segments_value_decoder.sv
// rtl/seven_segments_value_decoder.sv - 8-bit value to two seven-segment patterns (decimal via double dabble, or hex)
module seven_segments_value_decoder #(
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input logic                          i_clock,
  input logic                          i_reset_n,
  seven_segments_value_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CONVERT, DECODE} state_t;

  state_t      state, state_next;
  logic [19:0] shift;
  logic [19:0] adjusted;
  logic [2:0]  count;
  logic        hex_q;
  logic        accept;
  logic [3:0]  hi_src, lo_src;
  logic        dash;
  logic [6:0]  seg_hi_next, seg_lo_next;
  logic [6:0]  seg_hi, seg_lo;
  logic        done;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Hundreds/tens/ones occupy [19:8]; the binary value shifts out of [7:0].
  always_comb begin
    adjusted = {add3(shift[19:16]), add3(shift[15:12]), add3(shift[11:8]), shift[7:0]};
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_valid) begin
          accept     = 1'b1;
          state_next = bus.i_hex_mode ? DECODE : CONVERT;
        end
      end
      CONVERT: begin
        if (count == 3'd7) state_next = DECODE;
      end
      DECODE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Hex mode reuses the low byte of the shift register as the latched value.
  always_comb begin
    hi_src = shift[15:12];
    lo_src = shift[11:8];
    dash   = 1'b0;
    if (hex_q) begin
      hi_src = shift[7:4];
      lo_src = shift[3:0];
    end else begin
      dash = (shift[19:16] != 4'd0);
    end
    seg_lo_next = dash ? 7'h40 : glyph(lo_src);
    if (dash)
      seg_hi_next = 7'h40;
    else if (BLANK_LEADING_ZERO && hi_src == 4'd0)
      seg_hi_next = 7'h00;
    else
      seg_hi_next = glyph(hi_src);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      shift  <= '0;
      count  <= '0;
      hex_q  <= 1'b0;
      seg_hi <= 7'h00;
      seg_lo <= 7'h00;
      done   <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      if (accept) begin
        shift <= {12'b0, bus.i_value};
        count <= 3'd0;
        hex_q <= bus.i_hex_mode;
      end else if (state == CONVERT) begin
        shift <= adjusted << 1;
        count <= count + 3'd1;
      end
      if (state == DECODE) begin
        seg_hi <= seg_hi_next;
        seg_lo <= seg_lo_next;
        done   <= 1'b1;
      end
    end
  end

  assign bus.o_busy             = (state != IDLE);
  assign bus.o_done             = done;
  assign bus.o_segments_digit_0 = seg_lo;
  assign bus.o_segments_digit_1 = seg_hi;

endmodule

// File: tb/tb_seven_segments_value_decoder.sv
// tb/tb_seven_segments_value_decoder.sv - directed self-checking bench for seven_segments_value_decoder
module tb_seven_segments_value_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seven_segments_value_decoder_if bus1 ();
  seven_segments_value_decoder_if bus0 ();

  seven_segments_value_decoder #(.BLANK_LEADING_ZERO(1'b1)) dut1 (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .bus      (bus1.slave)
  );

  seven_segments_value_decoder #(.BLANK_LEADING_ZERO(1'b0)) dut0 (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .bus      (bus0.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] v, input logic hex, input logic valid);
    bus1.i_value = v; bus1.i_hex_mode = hex; bus1.i_valid = valid;
    bus0.i_value = v; bus0.i_hex_mode = hex; bus0.i_valid = valid;
  endtask

  task automatic request(input logic [7:0] v, input logic hex, output int busy_cycles, output bit got_done);
    @(negedge clk);
    drive(v, hex, 1'b1);
    @(posedge clk);
    #1 drive(v, hex, 1'b0);
    busy_cycles = 0;
    got_done = 1'b0;
    for (int i = 0; i < 30 && !got_done; i++) begin
      @(negedge clk);
      if (bus1.o_done) got_done = 1'b1;
      else if (bus1.o_busy) busy_cycles++;
    end
  endtask

  initial begin
    int bc;
    bit gd;
    int pulses;
    logic [6:0] s1, s0;

    drive(8'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_busy", bus1.o_busy, 1'b0);
    check("reset_done", bus1.o_done, 1'b0);
    check("reset_d1", bus1.o_segments_digit_1, 7'h00);
    check("reset_d0", bus1.o_segments_digit_0, 7'h00);
    rst_n = 1'b1;

    request(8'd42, 1'b0, bc, gd);
    check("dec42_done", gd, 1'b1);
    check("dec42_busy_cycles", bc, 9);
    check("dec42_d1", bus1.o_segments_digit_1, 7'h66);
    check("dec42_d0", bus1.o_segments_digit_0, 7'h5B);
    @(negedge clk);
    check("dec42_done_one_cycle", bus1.o_done, 1'b0);

    request(8'd7, 1'b0, bc, gd);
    check("dec7_d1_blank", bus1.o_segments_digit_1, 7'h00);
    check("dec7_d0", bus1.o_segments_digit_0, 7'h07);
    check("dec7_d1_noblank", bus0.o_segments_digit_1, 7'h3F);
    check("dec7_d0_noblank", bus0.o_segments_digit_0, 7'h07);

    request(8'd0, 1'b0, bc, gd);
    check("dec0_d1", bus1.o_segments_digit_1, 7'h00);
    check("dec0_d0", bus1.o_segments_digit_0, 7'h3F);

    request(8'd99, 1'b0, bc, gd);
    check("dec99_d1", bus1.o_segments_digit_1, 7'h6F);
    check("dec99_d0", bus1.o_segments_digit_0, 7'h6F);

    request(8'd100, 1'b0, bc, gd);
    check("dec100_d1", bus1.o_segments_digit_1, 7'h40);
    check("dec100_d0", bus1.o_segments_digit_0, 7'h40);

    request(8'd255, 1'b0, bc, gd);
    check("dec255_d1", bus1.o_segments_digit_1, 7'h40);
    check("dec255_d0", bus1.o_segments_digit_0, 7'h40);

    request(8'd10, 1'b0, bc, gd);
    check("dec10_d1", bus1.o_segments_digit_1, 7'h06);
    check("dec10_d0", bus1.o_segments_digit_0, 7'h3F);

    // Hex A5, with i_valid held high across the DECODE edge: that request must be dropped.
    @(negedge clk);
    drive(8'hA5, 1'b1, 1'b1);
    @(posedge clk);
    #1 drive(8'h0F, 1'b1, 1'b1);
    @(posedge clk);
    #1 drive(8'h0F, 1'b1, 1'b0);
    @(negedge clk);
    check("hexA5_done", bus1.o_done, 1'b1);
    check("hexA5_busy_after_e1", bus1.o_busy, 1'b0);
    check("hexA5_d1", bus1.o_segments_digit_1, 7'h77);
    check("hexA5_d0", bus1.o_segments_digit_0, 7'h6D);
    @(negedge clk);
    check("hex_decode_edge_valid_ignored", bus1.o_busy, 1'b0);

    request(8'h0F, 1'b1, bc, gd);
    check("hex0F_busy_cycles", bc, 1);
    check("hex0F_d1_blank", bus1.o_segments_digit_1, 7'h00);
    check("hex0F_d0", bus1.o_segments_digit_0, 7'h71);
    check("hex0F_d1_noblank", bus0.o_segments_digit_1, 7'h3F);

    // Second request arrives mid-conversion and must not be queued.
    @(negedge clk);
    drive(8'd42, 1'b0, 1'b1);
    @(posedge clk);
    #1 drive(8'd42, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 drive(8'd13, 1'b0, 1'b1);
    @(posedge clk);
    #1 drive(8'd13, 1'b0, 1'b0);
    pulses = 0;
    s1 = 7'h00;
    s0 = 7'h00;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus1.o_done) begin
        pulses++;
        s1 = bus1.o_segments_digit_1;
        s0 = bus1.o_segments_digit_0;
      end
    end
    check("busy_drop_pulses", pulses, 1);
    check("busy_drop_d1", s1, 7'h66);
    check("busy_drop_d0", s0, 7'h5B);

    // Reset in the middle of CONVERT aborts with no done pulse.
    @(negedge clk);
    drive(8'd42, 1'b0, 1'b1);
    @(posedge clk);
    #1 drive(8'd42, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", bus1.o_busy, 1'b0);
    check("abort_d1", bus1.o_segments_digit_1, 7'h00);
    check("abort_d0", bus1.o_segments_digit_0, 7'h00);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus1.o_done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    rst_n = 1'b1;

    request(8'd5, 1'b0, bc, gd);
    check("after_abort_done", gd, 1'b1);
    check("dec5_d1", bus1.o_segments_digit_1, 7'h00);
    check("dec5_d0", bus1.o_segments_digit_0, 7'h6D);
    check("dec5_d1_noblank", bus0.o_segments_digit_1, 7'h3F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
